// File: rtl/pit_lookup_table_pkg.sv
// Shared PIT types: request opcodes, scan FSM states and the default buffer address width.
package pit_lookup_table_pkg;

  localparam int unsigned PIT_ADDR_W = 10;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } pit_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_UPDATE = 2'd2
  } pit_state_e;

endpackage

// File: rtl/pit_lookup_table_if.sv
// Request/response bus between the name-hash stage (master) and the PIT lookup table (slave).
interface pit_lookup_table_if #(
  parameter int unsigned KEY_W  = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned OCC_W  = 5
);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [KEY_W-1:0]  req_key;
  logic              resp_valid;
  logic [ADDR_W:0]   table_entry;
  logic              resp_full;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output req_valid, req_op, req_key,
    input  req_ready, resp_valid, table_entry, resp_full, occupancy
  );

  modport slave (
    input  req_valid, req_op, req_key,
    output req_ready, resp_valid, table_entry, resp_full, occupancy
  );

endinterface

// File: rtl/pit_lookup_table_tick_gen.sv
// Free-running lifetime prescaler: one-cycle tick every TICK_DIV clocks.
module pit_lookup_table_tick_gen #(
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CNT_MAX);
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pit_lookup_table.sv
// PIT pending-interest table: sequential-scan lookup/insert responder with per-entry lifetimes.
// table_entry = {hit, buffer address}; slot k owns buffer base k * (2**ADDR_W / ENTRIES).
module pit_lookup_table
  import pit_lookup_table_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned KEY_W    = 16,
  parameter int unsigned ADDR_W   = PIT_ADDR_W,
  parameter int unsigned LIFE_W   = 8,
  parameter int unsigned LIFETIME = 200,
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic              clk,
  input  logic              reset,
  pit_lookup_table_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned OCC_W  = IDX_W + 1;
  localparam int unsigned STRIDE = (2 ** ADDR_W) / ENTRIES;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0] i);
    return ADDR_W'(32'(i) * STRIDE);
  endfunction

  pit_state_e        state_q, state_d;
  pit_op_e           op_q, op_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              hit_q, hit_d;
  logic              free_ok_q, free_ok_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [KEY_W-1:0]  keys_q [ENTRIES];
  logic [KEY_W-1:0]  keys_d [ENTRIES];
  logic [LIFE_W-1:0] life_q [ENTRIES];
  logic [LIFE_W-1:0] life_d [ENTRIES];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_full_q, resp_full_d;
  logic [ADDR_W:0]   table_entry_q, table_entry_d;

  logic              tick;
  logic              accept_c;
  logic              cmp_hit_c;
  logic              last_c;
  logic              upd_sel_c;
  logic [IDX_W-1:0]  upd_idx_c;
  logic              alloc_c;
  logic              consume_c;
  logic [OCC_W-1:0]  n_exp_c;

  pit_lookup_table_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign accept_c  = bus.req_valid && req_ready_q;
  assign cmp_hit_c = valid_q[idx_q] && (keys_q[idx_q] == key_q);
  assign last_c    = (idx_q == IDX_W'(ENTRIES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Scan sequencing: early exit on the first valid key match.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_SEARCH;
      ST_SEARCH: if (cmp_hit_c || last_c) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d          = op_q;
    key_d         = key_q;
    idx_d         = idx_q;
    hit_d         = hit_q;
    free_ok_d     = free_ok_q;
    free_idx_d    = free_idx_q;
    valid_d       = valid_q;
    keys_d        = keys_q;
    life_d        = life_q;
    req_ready_d   = (state_d == ST_IDLE);
    resp_valid_d  = 1'b0;
    resp_full_d   = resp_full_q;
    table_entry_d = table_entry_q;
    upd_sel_c     = 1'b0;
    upd_idx_c     = idx_q;
    alloc_c       = 1'b0;
    consume_c     = 1'b0;
    n_exp_c       = '0;

    // The slot touched by UPDATE skips this edge's tick: the action wins.
    if (state_q == ST_UPDATE) begin
      if (hit_q) begin
        upd_sel_c = 1'b1;
      end else if (op_q == OP_INSERT && free_ok_q) begin
        upd_sel_c = 1'b1;
        upd_idx_c = free_idx_q;
      end
    end

    if (tick) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (valid_q[i] && !(upd_sel_c && upd_idx_c == IDX_W'(i))) begin
          if (life_q[i] == LIFE_W'(1)) begin
            valid_d[i] = 1'b0;
            life_d[i]  = '0;
            n_exp_c    = n_exp_c + OCC_W'(1);
          end else begin
            life_d[i] = life_q[i] - LIFE_W'(1);
          end
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d      = pit_op_e'(bus.req_op);
          key_d     = bus.req_key;
          idx_d     = '0;
          hit_d     = 1'b0;
          free_ok_d = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (!valid_q[idx_q] && !free_ok_q) begin
          free_ok_d  = 1'b1;
          free_idx_d = idx_q;
        end
        if (cmp_hit_c)    hit_d = 1'b1;
        else if (!last_c) idx_d = idx_q + IDX_W'(1);
      end
      ST_UPDATE: begin
        resp_valid_d  = 1'b1;
        resp_full_d   = 1'b0;
        table_entry_d = '0;
        if (hit_q) begin
          table_entry_d = {1'b1, slot_addr(idx_q)};
          if (op_q == OP_LOOKUP) begin
            valid_d[idx_q] = 1'b0;
            life_d[idx_q]  = '0;
            consume_c      = valid_q[idx_q];
          end else begin
            // A match that expired after its compare is brought back by the refresh.
            valid_d[idx_q] = 1'b1;
            life_d[idx_q]  = LIFE_W'(LIFETIME);
            alloc_c        = !valid_q[idx_q];
          end
        end else if (op_q == OP_INSERT) begin
          if (free_ok_q) begin
            valid_d[free_idx_q] = 1'b1;
            keys_d[free_idx_q]  = key_q;
            life_d[free_idx_q]  = LIFE_W'(LIFETIME);
            alloc_c             = 1'b1;
            table_entry_d       = {1'b0, slot_addr(free_idx_q)};
          end else begin
            resp_full_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    occ_d = occ_q + OCC_W'(alloc_c) - OCC_W'(consume_c) - n_exp_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q          <= OP_LOOKUP;
      key_q         <= '0;
      idx_q         <= '0;
      hit_q         <= 1'b0;
      free_ok_q     <= 1'b0;
      free_idx_q    <= '0;
      valid_q       <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        keys_q[i] <= '0;
        life_q[i] <= '0;
      end
      occ_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_full_q   <= 1'b0;
      table_entry_q <= '0;
    end else begin
      op_q          <= op_d;
      key_q         <= key_d;
      idx_q         <= idx_d;
      hit_q         <= hit_d;
      free_ok_q     <= free_ok_d;
      free_idx_q    <= free_idx_d;
      valid_q       <= valid_d;
      keys_q        <= keys_d;
      life_q        <= life_d;
      occ_q         <= occ_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_full_q   <= resp_full_d;
      table_entry_q <= table_entry_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_full   = resp_full_q;
  assign bus.table_entry = table_entry_q;
  assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_pit_lookup_table.sv
// Bench for pit_lookup_table: directed scenarios plus random traffic against a
// time-stamped table model (each slot remembers the edge at which it expires).
module tb_pit_lookup_table;
  import pit_lookup_table_pkg::*;

  localparam int ENTRIES  = 16;
  localparam int KEY_W    = 16;
  localparam int ADDR_W   = 10;
  localparam int LIFE_W   = 8;
  localparam int LIFETIME = 100;  // long enough to fill the table before the first entry ages out
  localparam int TICK_DIV = 4;
  localparam int OCC_W    = $clog2(ENTRIES) + 1;
  localparam int STRIDE   = (2 ** ADDR_W) / ENTRIES;
  localparam int HIT_VAL  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pit_lookup_table_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .OCC_W(OCC_W)) bus ();

  pit_lookup_table #(
    .ENTRIES (ENTRIES),
    .KEY_W   (KEY_W),
    .ADDR_W  (ADDR_W),
    .LIFE_W  (LIFE_W),
    .LIFETIME(LIFETIME),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int edge_n;               // rising edges since reset release
  int m_exp [ENTRIES];      // edge at which the slot stops being valid (0 = never filled)
  logic [KEY_W-1:0] m_key [ENTRIES];
  int last_te;

  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Prescaler starts at 0 on release; its tick is registered, so decrements land on edges TICK_DIV+1, 2*TICK_DIV+1, ...
  function automatic bit tick_at(input int n);
    return (n > TICK_DIV) && (((n - 1) % TICK_DIV) == 0);
  endfunction

  function automatic int expiry(input int load_edge);
    int n;
    int c;
    n = load_edge;
    c = 0;
    while (c < LIFETIME) begin
      n++;
      if (tick_at(n)) c++;
    end
    return n;
  endfunction

  function automatic int model_occ(input int n);
    int c;
    c = 0;
    for (int i = 0; i < ENTRIES; i++) if (m_exp[i] > n) c++;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < ENTRIES; i++) m_exp[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_occupancy", int'(bus.occupancy), 0);
    chk("rst_table_entry", int'(bus.table_entry), 0);
    chk("rst_resp_full", int'(bus.resp_full), 0);
    reset = 1'b1;
    last_te = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_occupancy", int'(bus.occupancy), model_occ(edge_n));
      chk("idle_resp_valid", int'(bus.resp_valid), 0);
      chk("idle_hold_entry", int'(bus.table_entry), last_te);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where the response is visible.
  task automatic do_req(input pit_op_e op, input logic [KEY_W-1:0] key);
    int a, u, k, f, te;
    bit hit, full, got;
    a = edge_n + 1;
    hit = 1'b0; full = 1'b0; k = 0; f = -1; te = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_exp[i] > a + i) begin
        if (m_key[i] == key) begin
          hit = 1'b1;
          k = i;
          break;
        end
      end else if (f < 0) begin
        f = i;
      end
    end
    u = hit ? (a + k + 2) : (a + ENTRIES + 1);
    if (hit) begin
      te = HIT_VAL + k * STRIDE;
      if (op == OP_LOOKUP) m_exp[k] = 0;
      else                 m_exp[k] = expiry(u);
    end else if (op == OP_INSERT && f >= 0) begin
      m_key[f] = key;
      m_exp[f] = expiry(u);
      te = f * STRIDE;
    end else if (op == OP_INSERT) begin
      full = 1'b1;
    end

    chk("req_ready", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < ENTRIES + 8 && !got; c++) begin
      @(negedge clk);
      got = bus.resp_valid;
    end
    chk("resp_seen", int'(got), 1);
    chk("latency", edge_n - a, u - a);
    chk("table_entry", int'(bus.table_entry), te);
    chk("resp_full", int'(bus.resp_full), int'(full));
    chk("occupancy", int'(bus.occupancy), model_occ(edge_n));
    last_te = te;
  endtask

  initial begin
    pit_op_e op;
    logic [KEY_W-1:0] key;
    bit saw;

    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_key   = '0;
    reset         = 1'b0;
    last_te       = 0;
    do_reset();

    // Insert, aggregate, consume.
    do_req(OP_INSERT, 16'hBEEF);
    chk("t1_first_slot", int'(bus.table_entry), 'h000);
    do_req(OP_INSERT, 16'h1234);
    chk("t1_second_slot", int'(bus.table_entry), 'h040);
    do_req(OP_INSERT, 16'h1234);
    chk("t2_aggregate", int'(bus.table_entry), 'h440);
    chk("t2_occupancy", int'(bus.occupancy), 2);
    do_req(OP_LOOKUP, 16'hBEEF);
    chk("t3_consume", int'(bus.table_entry), 'h400);
    do_req(OP_LOOKUP, 16'hBEEF);
    chk("t3_gone", int'(bus.table_entry), 'h000);
    idle(3);

    // Fill the table, then overflow it.
    do_reset();
    for (int i = 0; i < ENTRIES; i++) do_req(OP_INSERT, 16'h0100 + 16'(i));
    chk("t4_occ_full", int'(bus.occupancy), ENTRIES);
    do_req(OP_INSERT, 16'h0999);
    chk("t4_full_flag", int'(bus.resp_full), 1);
    chk("t4_full_entry", int'(bus.table_entry), 0);
    do_req(OP_LOOKUP, 16'h0105);
    chk("t4_full_cleared", int'(bus.resp_full), 0);
    chk("t4_lookup_hit", int'(bus.table_entry), 'h540);

    // Expiry of an untouched entry.
    do_reset();
    do_req(OP_INSERT, 16'h5A5A);
    idle(LIFETIME * TICK_DIV + 8);
    chk("t5_expired_occ", int'(bus.occupancy), 0);
    do_req(OP_LOOKUP, 16'h5A5A);
    chk("t5_expired_miss", int'(bus.table_entry), 0);

    // Refresh whose UPDATE edge coincides with a tick.
    do_reset();
    do_req(OP_INSERT, 16'h7777);
    for (int c = 0; c < TICK_DIV && !tick_at(edge_n + 3); c++) idle(1);
    do_req(OP_INSERT, 16'h7777);
    chk("t5_refresh_hit", int'(bus.table_entry), 'h400);
    idle(LIFETIME * TICK_DIV + 8);

    // Reset in the middle of a scan.
    do_req(OP_INSERT, 16'h4444);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_INSERT;
    bus.req_key   = 16'h4545;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    saw = 1'b0;
    for (int c = 0; c < ENTRIES + 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) saw = 1'b1;
    end
    chk("t6_no_resp", int'(saw), 0);
    chk("t6_occupancy", int'(bus.occupancy), 0);
    chk("t6_req_ready", int'(bus.req_ready), 1);

    // Random traffic over a small key pool so hits, fills and expiries all occur.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      op  = ($urandom_range(0, 99) < 60) ? OP_INSERT : OP_LOOKUP;
      key = 16'h2000 + 16'($urandom_range(0, 23));
      do_req(op, key);
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(20, 300)));
      else                           idle(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
